// File: rtl/uart_rx_sample_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sample_assembler
// Description : 8N1 UART receiver that packs little-endian bytes into
//               SAMPLE_W-bit samples, with framing-error and flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sample_assembler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SAMPLE_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    input  logic                flush,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int c_BYTES = SAMPLE_W / 8;
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_BYTES - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_STOP      = 3'd3;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd4;

    logic [1:0]          r_sync;
    logic [2:0]          r_state;
    logic [c_CNT_W-1:0]  r_clk_cnt;
    logic [2:0]          r_bit_idx;
    logic [c_IDX_W-1:0]  r_byte_idx;
    logic [7:0]          r_shift;
    logic [SAMPLE_W-1:0] r_asm;
    logic [SAMPLE_W-1:0] r_sample_out;
    logic                r_sample_valid;
    logic                r_frame_err;

    logic                w_rxs;
    logic [2:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  w_clk_cnt_nxt;
    logic [2:0]          w_bit_idx_nxt;
    logic [c_IDX_W-1:0]  w_byte_idx_nxt;
    logic [7:0]          w_shift_nxt;
    logic [SAMPLE_W-1:0] w_asm_nxt;
    logic [SAMPLE_W-1:0] w_asm_ins;
    logic [SAMPLE_W-1:0] w_sample_out_nxt;
    logic                w_sample_valid_nxt;
    logic                w_frame_err_nxt;

    // Synchronizer resets to the idle-high line level so reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rxs = r_sync[1];

    always_comb begin
        w_state_nxt        = r_state;
        w_clk_cnt_nxt      = r_clk_cnt;
        w_bit_idx_nxt      = r_bit_idx;
        w_byte_idx_nxt     = r_byte_idx;
        w_shift_nxt        = r_shift;
        w_asm_nxt          = r_asm;
        w_sample_out_nxt   = r_sample_out;
        w_sample_valid_nxt = 1'b0;
        w_frame_err_nxt    = 1'b0;
        w_asm_ins          = r_asm;
        w_asm_ins[{r_byte_idx, 3'b000} +: 8] = r_shift;

        case (r_state)
            c_ST_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt   = c_ST_START;
                    w_clk_cnt_nxt = '0;
                end
            end
            c_ST_START: begin
                if (r_clk_cnt == c_HALF) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rxs ? c_ST_IDLE : c_ST_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            c_ST_DATA: begin
                if (r_clk_cnt == c_FULL) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {w_rxs, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = c_ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            c_ST_STOP: begin
                if (r_clk_cnt == c_FULL) begin
                    w_clk_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_state_nxt = c_ST_IDLE;
                        if (r_byte_idx == c_LAST) begin
                            w_sample_out_nxt   = w_asm_ins;
                            w_sample_valid_nxt = 1'b1;
                            w_asm_nxt          = '0;
                            w_byte_idx_nxt     = '0;
                        end else begin
                            w_asm_nxt      = w_asm_ins;
                            w_byte_idx_nxt = r_byte_idx + 1'b1;
                        end
                    end else begin
                        // Bad stop bit drops the whole partial sample, not just this byte.
                        w_frame_err_nxt = 1'b1;
                        w_byte_idx_nxt  = '0;
                        w_asm_nxt       = '0;
                        w_state_nxt     = c_ST_WAIT_HIGH;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            c_ST_WAIT_HIGH: begin
                if (w_rxs) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Flush outranks any completion or framing error landing in the same cycle.
        if (flush) begin
            w_state_nxt        = w_rxs ? c_ST_IDLE : c_ST_WAIT_HIGH;
            w_clk_cnt_nxt      = '0;
            w_bit_idx_nxt      = '0;
            w_byte_idx_nxt     = '0;
            w_shift_nxt        = '0;
            w_asm_nxt          = '0;
            w_sample_out_nxt   = '0;
            w_sample_valid_nxt = 1'b0;
            w_frame_err_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= c_ST_IDLE;
            r_clk_cnt      <= '0;
            r_bit_idx      <= '0;
            r_byte_idx     <= '0;
            r_shift        <= '0;
            r_asm          <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_clk_cnt      <= w_clk_cnt_nxt;
            r_bit_idx      <= w_bit_idx_nxt;
            r_byte_idx     <= w_byte_idx_nxt;
            r_shift        <= w_shift_nxt;
            r_asm          <= w_asm_nxt;
            r_sample_out   <= w_sample_out_nxt;
            r_sample_valid <= w_sample_valid_nxt;
            r_frame_err    <= w_frame_err_nxt;
        end
    end

    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign frame_err    = r_frame_err;
    assign busy         = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
